// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Constants and FSM encoding shared by the FIFO write path.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DATA_W  = 8;
    localparam int FIFO_MAX_REQ = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, first valid at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic           w_found;
    logic [IDX_W:0] w_cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_i[w_cand[IDX_W-1:0]]) begin
                w_found                       = 1'b1;
                onehot_o[w_cand[IDX_W-1:0]]   = 1'b1;
                idx_o                         = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Packet-locked round-robin arbiter for the FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = FIFO_DATA_W,
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_write,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [2:0]                  timeout_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [IDX_W-1:0]   win_idx_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic               timeout_err_q;
    logic [2:0]         timeout_id_q;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_xfer;
    logic               w_accept;
    logic               w_stall;
    logic               w_timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (w_pick_onehot),
        .idx_o    (w_pick_idx),
        .any_o    (w_pick_any)
    );

    assign w_xfer     = (state_q == ST_XFER);
    assign req_ready  = w_xfer ? (grant_q & {NUM_REQ{~fifo_full}}) : '0;
    assign w_accept   = |(req_valid & req_ready);
    assign fifo_write = w_accept;
    assign fifo_data  = w_accept ? req_data[win_idx_q*DATA_W +: DATA_W] : '0;

    // Only stalls caused by the grantee count; FIFO back-pressure never does.
    assign w_stall     = w_xfer & ~req_valid[win_idx_q] & ~fifo_full;
    assign w_timeout   = w_stall & (stall_cnt_q == CNT_W'(IDLE_TIMEOUT - 1));
    assign stall_cnt_d = (stall_cnt_q == CNT_W'(IDLE_TIMEOUT)) ? stall_cnt_q
                                                               : stall_cnt_q + 1'b1;
    assign rr_ptr_d    = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            win_idx_q     <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    stall_cnt_q <= '0;
                    if (en && w_pick_any) begin
                        grant_q   <= w_pick_onehot;
                        win_idx_q <= w_pick_idx;
                        state_q   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept && req_last[win_idx_q]) begin
                        grant_q     <= '0;
                        rr_ptr_q    <= rr_ptr_d;
                        stall_cnt_q <= '0;
                        state_q     <= ST_IDLE;
                    end else if (w_accept) begin
                        stall_cnt_q <= '0;
                    end else if (w_timeout) begin
                        timeout_err_q <= 1'b1;
                        timeout_id_q  <= 3'(win_idx_q);
                        grant_q       <= '0;
                        rr_ptr_q      <= rr_ptr_d;
                        stall_cnt_q   <= '0;
                        state_q       <= ST_IDLE;
                    end else if (w_stall) begin
                        stall_cnt_q <= stall_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = w_xfer;
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Scoreboard bench for fifo_write_arbiter with directed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [7:0]  fifo_data;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  timeout_id;

    fifo_write_arbiter #(
        .NUM_REQ      (4),
        .DATA_W       (8),
        .IDLE_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_write  (fifo_write),
        .fifo_data   (fifo_data),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          prev_wr = -1;
    logic        gap_chk = 1'b0;
    logic [3:0]  hold = '0;
    logic [3:0]  acc = '0;
    logic [8:0]  src_q [4][$];
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;
    logic [8:0]  drv_tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int r, input logic last, input logic [7:0] d);
        src_q[r].push_back({last, d});
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    function automatic logic srcs_empty();
        return (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
               (src_q[2].size() == 0) && (src_q[3].size() == 0);
    endfunction

    task automatic wait_grant(input logic [3:0] g, input string name);
        for (int k = 0; k < 50 && grant !== g; k++) @(negedge clk);
        chk(name, grant, g);
    endtask

    task automatic wait_write(input string name);
        for (int k = 0; k < 50 && fifo_write !== 1'b1; k++) @(negedge clk);
        chk(name, fifo_write, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300 && !(exp_q.size() == 0 && busy === 1'b0 && srcs_empty()); k++)
            @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake is decided by the values just before the edge; capture them mid-cycle.
    always @(negedge clk) acc = req_valid & req_ready;

    // Source model: each requester presents the head of its byte queue.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && src_q[i].size() > 0) drv_tmp = src_q[i].pop_front();
            if (!hold[i] && src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = src_q[i][0][8];
                req_data[i*8 +: 8] = src_q[i][0][7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Scoreboard monitor: every FIFO write must match the next expected byte and owner.
    always @(negedge clk) begin
        if (fifo_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %0h grant %b, required no write (t=%0t)",
                         fifo_data, grant, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_data", fifo_data, mon_e[7:0]);
                chk("wr_grant", grant, mon_e[11:8]);
                if (gap_chk && prev_wr >= 0) chk("rr_gap", cyc - prev_wr, 2);
            end
            prev_wr = cyc;
        end
    end

    initial begin
        int wc;

        // Reset with every requester valid; round-robin packets queued behind it.
        reset_n = 1'b0;
        push_src(0, 1'b1, 8'h10); push_src(1, 1'b1, 8'h11);
        push_src(2, 1'b1, 8'h12); push_src(3, 1'b1, 8'h13);
        push_src(0, 1'b1, 8'h10);
        push_exp(4'b0001, 8'h10); push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12); push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h10);
        repeat (3) @(negedge clk);
        chk("rst_valid_stim", req_valid, 4'hF);
        chk("rst_grant", grant, 4'h0);
        chk("rst_fifo_write", fifo_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_timeout_id", timeout_id, 3'd0);

        gap_chk = 1'b1;
        reset_n = 1'b1;
        drain("rr_drain");
        gap_chk = 1'b0;

        // Packet lock: req0 owns the port for all three bytes.
        push_src(0, 1'b0, 8'hA1); push_src(0, 1'b0, 8'hA2); push_src(0, 1'b1, 8'hA3);
        push_exp(4'b0001, 8'hA1); push_exp(4'b0001, 8'hA2); push_exp(4'b0001, 8'hA3);
        wait_grant(4'b0001, "lock_grant0");
        push_src(2, 1'b1, 8'hC2);
        push_exp(4'b0100, 8'hC2);
        drain("lock_drain");

        // Back-pressure mid-packet, held well past the idle timeout.
        push_src(1, 1'b0, 8'hB1); push_src(1, 1'b0, 8'hB2);
        push_src(1, 1'b0, 8'hB3); push_src(1, 1'b1, 8'hB4);
        push_exp(4'b0010, 8'hB1); push_exp(4'b0010, 8'hB2);
        push_exp(4'b0010, 8'hB3); push_exp(4'b0010, 8'hB4);
        wait_write("bp_first_write");
        @(posedge clk); #2;
        fifo_full = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 4'h0);
            chk("bp_fifo_write", fifo_write, 1'b0);
            chk("bp_no_timeout", timeout_err, 1'b0);
        end
        chk("bp_grant_held", grant, 4'b0010);
        @(posedge clk); #2;
        fifo_full = 1'b0;
        drain("bp_drain");

        // Timeout: req1 sends one non-final byte, then goes silent.
        push_src(1, 1'b0, 8'hD1);
        push_exp(4'b0010, 8'hD1);
        wait_write("to_first_write");
        wc = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) break;
        end
        chk("to_pulse", timeout_err, 1'b1);
        chk("to_delay", cyc - wc, 16);
        chk("to_id", timeout_id, 3'd1);
        chk("to_grant", grant, 4'h0);
        chk("to_busy", busy, 1'b0);
        @(negedge clk);
        chk("to_pulse_width", timeout_err, 1'b0);
        push_src(1, 1'b1, 8'hE1); push_src(2, 1'b1, 8'hE2);
        push_exp(4'b0100, 8'hE2); push_exp(4'b0010, 8'hE1);
        drain("to_drain");
        chk("to_id_held", timeout_id, 3'd1);

        // en=0 mid-packet: packet finishes, nothing new is granted.
        push_src(3, 1'b0, 8'hF1); push_src(3, 1'b0, 8'hF2); push_src(3, 1'b1, 8'hF3);
        push_exp(4'b1000, 8'hF1); push_exp(4'b1000, 8'hF2); push_exp(4'b1000, 8'hF3);
        wait_grant(4'b1000, "en_grant3");
        en = 1'b0;
        push_src(0, 1'b1, 8'h60);
        push_exp(4'b0001, 8'h60);
        for (int k = 0; k < 100 && !(exp_q.size() == 1 && busy === 1'b0); k++) @(negedge clk);
        chk("en_pkt_done", exp_q.size(), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("en_hold_grant", grant, 4'h0);
            chk("en_hold_busy", busy, 1'b0);
        end
        en = 1'b1;
        drain("en_drain");

        // Reset mid-packet: abort after first byte, pointer returns to 0.
        push_src(2, 1'b0, 8'h71); push_src(2, 1'b0, 8'h72);
        push_src(2, 1'b0, 8'h73); push_src(2, 1'b1, 8'h74);
        push_exp(4'b0100, 8'h71);
        wait_write("rstmid_first_write");
        hold[2] = 1'b1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_grant", grant, 4'h0);
        chk("rstmid_fifo_write", fifo_write, 1'b0);
        src_q[2].delete();
        hold[2] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        push_src(1, 1'b1, 8'h81); push_src(3, 1'b1, 8'h83);
        push_exp(4'b0010, 8'h81); push_exp(4'b1000, 8'h83);
        drain("rstmid_drain");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
